// File: rtl/store_queue_if.sv
// Store queue handshake bundle: dispatch alloc, mem FU exec write, load
// forwarding lookup, ROB retire/flush and the dcache drain port.
// master = surrounding pipeline, slave = store_queue.
interface store_queue_if #(parameter int SQ_DEPTH = 8);
   localparam int IDX_W = $clog2(SQ_DEPTH);

   typedef struct packed {
      logic             valid;
      logic [31:0]      addr;
      logic [31:0]      data;
      logic [IDX_W-1:0] store_queue_idx;
   } exec_entry_t;

   logic             alloc_valid;
   logic [IDX_W-1:0] alloc_idx;
   logic             sq_full;
   exec_entry_t      exec_entry;
   logic             lookup_valid;
   logic [31:0]      lookup_addr;
   logic [IDX_W-1:0] lookup_sq_tail;
   logic             forward_valid;
   logic [31:0]      forward_data;
   logic             forward_stall;
   logic             retire_valid;
   logic             flush;
   logic             store_req;
   logic [31:0]      store_addr;
   logic [31:0]      store_data;
   logic             store_ack;

   modport master (
      output alloc_valid, exec_entry, lookup_valid, lookup_addr, lookup_sq_tail,
             retire_valid, flush, store_ack,
      input  alloc_idx, sq_full, forward_valid, forward_data, forward_stall,
             store_req, store_addr, store_data
   );

   modport slave (
      input  alloc_valid, exec_entry, lookup_valid, lookup_addr, lookup_sq_tail,
             retire_valid, flush, store_ack,
      output alloc_idx, sq_full, forward_valid, forward_data, forward_stall,
             store_req, store_addr, store_data
   );
endinterface

// File: rtl/store_queue.sv
// Circular store queue between dispatch/retire and the dcache.
// Optional store-to-load forwarding is built only when SQ_FORWARD_EN is
// defined; otherwise the forward_* outputs are tied 0.
//
// entry state | meaning
// E_FREE      | slot unused
// E_ALLOC     | dispatched, address/data not yet executed
// E_READY     | address/data captured, not yet retired
// E_COMMITTED | retired, waiting to drain to the dcache
module store_queue #(parameter int SQ_DEPTH = 8) (
   input logic          clock,
   input logic          reset,
   store_queue_if.slave sq
);
   localparam int IDX_W = $clog2(SQ_DEPTH);

   typedef enum logic [1:0] {E_FREE, E_ALLOC, E_READY, E_COMMITTED} entry_state_t;

   entry_state_t     st     [SQ_DEPTH];
   logic [29:0]      addr_q [SQ_DEPTH];
   logic [31:0]      data_q [SQ_DEPTH];
   logic [IDX_W-1:0] head, commit, tail;
   logic [IDX_W:0]   count;
   logic [IDX_W:0]   n_committed;
   logic             full, req, alloc_ok, retire_ok, ack_ok;
   logic [IDX_W-1:0] ex_idx;

   assign ex_idx    = sq.exec_entry.store_queue_idx;
   assign full      = (count == (IDX_W+1)'(SQ_DEPTH));
   assign req       = (st[head] == E_COMMITTED);
   assign alloc_ok  = sq.alloc_valid && !full && !sq.flush;
   assign retire_ok = sq.retire_valid && (st[commit] == E_READY);
   assign ack_ok    = sq.store_ack && req;

   assign sq.alloc_idx  = tail;
   assign sq.sq_full    = full;
   assign sq.store_req  = req;
   assign sq.store_addr = req ? {addr_q[head], 2'b00} : 32'h0;
   assign sq.store_data = req ? data_q[head] : 32'h0;

   // Number of committed entries; these are exactly the survivors of a flush.
   always_comb begin
      n_committed = '0;
      for (int i = 0; i < SQ_DEPTH; i++)
         if (st[i] == E_COMMITTED) n_committed = n_committed + 1'b1;
   end

   // Entry states, payload and pointers. Later assignments override earlier
   // ones, so flush freeing wins over a same-cycle exec write.
   always_ff @(posedge clock) begin
      if (reset) begin
         head   <= '0;
         commit <= '0;
         tail   <= '0;
         count  <= '0;
         for (int i = 0; i < SQ_DEPTH; i++) begin
            st[i]     <= E_FREE;
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (sq.exec_entry.valid && st[ex_idx] == E_ALLOC) begin
            st[ex_idx]     <= E_READY;
            addr_q[ex_idx] <= sq.exec_entry.addr[31:2];
            data_q[ex_idx] <= sq.exec_entry.data;
         end
         if (retire_ok) st[commit] <= E_COMMITTED;
         if (ack_ok)    st[head]   <= E_FREE;
         if (alloc_ok)  st[tail]   <= E_ALLOC;
         if (sq.flush) begin
            for (int i = 0; i < SQ_DEPTH; i++)
               if ((st[i] == E_ALLOC || st[i] == E_READY) &&
                   !(retire_ok && IDX_W'(i) == commit))
                  st[i] <= E_FREE;
         end

         head   <= head + IDX_W'(ack_ok);
         commit <= commit + IDX_W'(retire_ok);
         if (sq.flush) begin
            tail  <= commit + IDX_W'(retire_ok);
            count <= n_committed + (IDX_W+1)'(retire_ok) - (IDX_W+1)'(ack_ok);
         end else begin
            tail  <= tail + IDX_W'(alloc_ok);
            count <= count + (IDX_W+1)'(alloc_ok) - (IDX_W+1)'(ack_ok);
         end
      end
   end

   // Retiring a store whose address/data never arrived means the ROB and
   // queue disagree; flag it in simulation, the retire itself is dropped.
   always_ff @(posedge clock) begin
      if (!reset && sq.retire_valid)
         assert (st[commit] == E_READY)
            else $error("store_queue: retire of non-READY entry %0d", commit);
   end

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^sq.exec_entry.addr[1:0];

`ifdef SQ_FORWARD_EN
   logic [IDX_W-1:0] scan_len;
   logic [IDX_W-1:0] scan_slot;
   logic             fwd_hit, fwd_wait;
   logic [31:0]      fwd_word;

   assign scan_len = sq.lookup_sq_tail - head;

   // Walk oldest to youngest; a match clears any older pending ALLOC since
   // only unresolved stores younger than the match can alias the load.
   always_comb begin
      fwd_hit   = 1'b0;
      fwd_wait  = 1'b0;
      fwd_word  = '0;
      scan_slot = '0;
      for (int k = 0; k < SQ_DEPTH; k++) begin
         scan_slot = head + IDX_W'(k);
         if (IDX_W'(k) < scan_len) begin
            if ((st[scan_slot] == E_READY || st[scan_slot] == E_COMMITTED) &&
                addr_q[scan_slot] == sq.lookup_addr[31:2]) begin
               fwd_hit  = 1'b1;
               fwd_wait = 1'b0;
               fwd_word = data_q[scan_slot];
            end else if (st[scan_slot] == E_ALLOC) begin
               fwd_wait = 1'b1;
            end
         end
      end
   end

   assign sq.forward_stall = sq.lookup_valid && fwd_wait;
   assign sq.forward_valid = sq.lookup_valid && fwd_hit && !fwd_wait;
   assign sq.forward_data  = sq.forward_valid ? fwd_word : 32'h0;
`else
   logic unused_lookup;
   assign unused_lookup = ^{sq.lookup_valid, sq.lookup_addr, sq.lookup_sq_tail};

   assign sq.forward_valid = 1'b0;
   assign sq.forward_data  = 32'h0;
   assign sq.forward_stall = 1'b0;
`endif
endmodule

// File: doc/store_queue.md
# store_queue

Circular store queue sitting between dispatch/retire and the data cache, directly downstream of the memory functional unit. It allocates one slot per store at dispatch and captures address/data when the memory FU executes the store. It marks stores committed in program order at retire, then drains committed stores to the dcache one at a time. It also answers the memory FU's store-to-load forwarding lookups combinationally.

## Interface
- SQ_DEPTH, 8: number of entries; power of two ≥ 2; STOREQ_IDX width = $clog2(SQ_DEPTH)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  dispatch allocates one store slot this cycle
- alloc_idx  out  STOREQ_IDX  current tail; slot given to the dispatching store; loads record it as their SQ tail
- sq_full  out  1  count == SQ_DEPTH; dispatch stalls both stores and loads while high
- exec_entry  in  EXECUTE_STOREQ_ENTRY  {valid, addr, data, store_queue_idx} from mem_fu
- lookup_valid  in  1  load forwarding lookup request
- lookup_addr  in  ADDR  load address
- lookup_sq_tail  in  STOREQ_IDX  SQ tail recorded at load dispatch
- forward_valid  out  1  matching older store found with data
- forward_data  out  DATA  data of that store
- forward_stall  out  1  an older store has an unresolved address
- retire_valid  in  1  ROB retires the oldest uncommitted store
- flush  in  1  mispredict: discard all uncommitted entries
- store_req  out  1  head entry is committed and awaiting a dcache write
- store_addr  out  ADDR  head address, word-aligned
- store_data  out  DATA  head data
- store_ack  in  1  dcache accepted the write; pop the head

## Operation
- Per-entry state: FREE → ALLOC (on alloc) → READY (on exec write) → COMMITTED (on retire) → FREE (on store_ack at head).
- Three pointers are kept: head (oldest), commit (oldest uncommitted), tail (next free). A count register covers 0..SQ_DEPTH. All pointers wrap modulo SQ_DEPTH.
- Alloc with sq_full=1 is ignored; tail does not move.
- An exec write to an entry not in ALLOC is ignored. A write to an ALLOC entry stores addr/data and moves the entry to READY.
- Retire requires the entry at commit to be READY. Retire on an ALLOC or FREE entry is a protocol error: ignored, and a sim-only $error fires.
- Flush frees every entry from commit to tail-1 and sets tail ← commit. COMMITTED entries keep draining normally.
- Forwarding scan range is head .. lookup_sq_tail-1; the range is empty when lookup_sq_tail == head.
  - The youngest entry in range in READY/COMMITTED with addr[31:2] == lookup_addr[31:2] sets forward_valid=1 and forward_data to its data.
  - forward_stall=1 if any entry in range younger than that match, or any entry in range when there is no match, is in ALLOC.
  - When forward_stall=1, forward_valid=0.
- All forwarding outputs are 0 when lookup_valid=0.
- Only word stores are forwarded; address compare ignores addr[1:0].

## Timing
- Reset: all entries FREE, pointers and count 0; sq_full=0, alloc_idx=0, and forward_valid, forward_data, forward_stall, store_req, store_addr, store_data all 0.
- Reset mid-drain drops an outstanding store_req immediately in the reset cycle's following state.
- alloc_idx, sq_full, forward_* and store_* are combinational from registered state. Same-cycle exec writes are not visible to lookups; they are visible the next cycle.
- Alloc, exec write, retire, flush and store_ack all take effect at the next posedge.
- Any combination of alloc, exec write, retire, store_ack and flush may occur in the same cycle. Count updates by +alloc_accepted − ack.
- Flush has priority over an alloc in the same cycle: the alloc is dropped and tail = commit.
- A retire in the same cycle as flush is applied first, so the retired entry survives and commit advances before tail is set.
- store_req stays high, with stable addr/data, until store_ack. store_ack while store_req=0 is ignored.
- Full plus ack in the same cycle: the alloc is still rejected, because sq_full is evaluated on current count.

## Configuration
- SQ_FORWARD_EN defined: forwarding behaves as above.
- SQ_FORWARD_EN undefined: forward_valid, forward_data and forward_stall are tied 0, lookup inputs are ignored, and no scan logic is synthesized. Loads always go to the dcache.

## Test plan
- Reset, then alloc 8 stores → alloc_idx 0..7, sq_full=1 after the 8th. 9th alloc is ignored; tail stays 0.
- Alloc idx0, exec addr 0x100 data 0xDEAD, retire → store_req=1 with store_addr 0x100, store_data 0xDEAD. Hold 3 cycles without ack → outputs stable. Ack → store_req=0, count 0.
- Stores idx0 @0x200=0x11 and idx1 @0x200=0x22, both READY; lookup addr 0x202, sq_tail 2 → forward_valid=1, data 0x22. With sq_tail 1 → data 0x11. With sq_tail 0 → forward_valid=0, forward_stall=0.
- idx0 READY @0x300, idx1 in ALLOC; lookup 0x300, sq_tail 2 → forward_stall=1, forward_valid=0.
- Alloc 4 stores, retire 1, flush → tail=1, count=1, entries 1..3 FREE. Head still drains on ack. Next alloc returns idx1.
- Build with SQ_FORWARD_EN undefined and repeat the forwarding scenario → forward_valid=0 and forward_stall=0 throughout.
